// File: rtl/program_loader.sv
// Loads a RAM_BYTES program image from pins via a strobe/ack handshake into program RAM, holding the CPU in reset meanwhile.
// Optional LOADER_CHECKSUM_EN adds a trailing modulo-256 checksum byte. Latency is 3 cycles from pin strobe to the write.
module program_loader #(
    parameter int RAM_BYTES = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              strobe,
    input  logic [7:0]        data_in,
    output logic              ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    output logic              cpu_run_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, WAIT_STB, WRITE, WAIT_REL, DONE
`ifdef LOADER_CHECKSUM_EN
        , CHECK
`endif
    } state_t;

    state_t state, state_nxt;

    logic s1, s2, s3;
    logic stb_rise;
    logic ack_nxt, done_nxt, run_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0] data_nxt;
    logic start;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum, sum_nxt;
    logic chk_seen, chk_seen_nxt;
    logic err_q, err_nxt;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // s1/s2 synchronize the pin; s3 is the previous s2 for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= strobe;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign stb_rise = s2 & ~s3;
    assign mem_we   = (state == WRITE);
    assign busy     = (state != IDLE) && (state != DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ack_nxt   = ack;
        done_nxt  = done;
        run_nxt   = cpu_run_n;
        addr_nxt  = mem_addr;
        data_nxt  = mem_data;
        start     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_nxt      = sum;
        chk_seen_nxt = chk_seen;
        err_nxt      = err_q;
`endif
        case (state)
            IDLE: begin
                run_nxt = 1'b1;
                if (load_req) start = 1'b1;
            end
            WAIT_STB: begin
                if (stb_rise) begin
                    data_nxt  = data_in;
                    ack_nxt   = 1'b1;
                    state_nxt = WRITE;
`ifdef LOADER_CHECKSUM_EN
                    sum_nxt   = sum + data_in;
`endif
                end
            end
            WRITE: begin
                addr_nxt  = (mem_addr == ADDR_W'(RAM_BYTES - 1)) ? '0 : mem_addr + 1'b1;
                state_nxt = WAIT_REL;
            end
            WAIT_REL: begin
                if (!s2) begin
                    ack_nxt = 1'b0;
                    if (mem_addr == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        if (chk_seen) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                            run_nxt   = ~err_q;
                        end else begin
                            state_nxt = CHECK;
                        end
`else
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        run_nxt   = 1'b1;
`endif
                    end else begin
                        state_nxt = WAIT_STB;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                // Checksum byte is acknowledged but never written to RAM
                if (stb_rise) begin
                    ack_nxt      = 1'b1;
                    chk_seen_nxt = 1'b1;
                    err_nxt      = (data_in != sum);
                    state_nxt    = WAIT_REL;
                end
            end
`endif
            DONE: begin
                if (load_req) start = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        if (load_req && busy) start = 1'b1;

        if (start) begin
            state_nxt = WAIT_STB;
            addr_nxt  = '0;
            ack_nxt   = 1'b0;
            done_nxt  = 1'b0;
            run_nxt   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_nxt      = '0;
            chk_seen_nxt = 1'b0;
            err_nxt      = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack       <= 1'b0;
            done      <= 1'b0;
            cpu_run_n <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum       <= '0;
            chk_seen  <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            ack       <= ack_nxt;
            done      <= done_nxt;
            cpu_run_n <= run_nxt;
            mem_addr  <= addr_nxt;
            mem_data  <= data_nxt;
`ifdef LOADER_CHECKSUM_EN
            sum       <= sum_nxt;
            chk_seen  <= chk_seen_nxt;
            err_q     <= err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset, full load, held strobe, abort, idle strobe, optional checksum.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_req;
    logic       strobe;
    logic [7:0] data_in;
    logic       ack;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_we;
    logic       cpu_run_n;
    logic       busy;
    logic       done;
    logic       err;

    int n_chk  = 0;
    int n_pass = 0;
    logic [11:0] wq[$];

    program_loader #(.RAM_BYTES(16), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_req  (load_req),
        .strobe    (strobe),
        .data_in   (data_in),
        .ack       (ack),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .cpu_run_n (cpu_run_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we) wq.push_back({mem_addr, mem_data});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        strobe  = 1'b1;
        data_in = b;
        n = 0;
        while (!ack && n < 20) begin tick(); n++; end
        check("ack_rise", {31'b0, ack}, 32'd1);
        strobe = 1'b0;
        n = 0;
        while (ack && n < 20) begin tick(); n++; end
        check("ack_fall", {31'b0, ack}, 32'd0);
        tick();
    endtask

    initial begin
        int n_ack, first_ack, n_fall;
        logic [11:0] e;
        rst_n = 1'b0; load_req = 1'b0; strobe = 1'b0; data_in = 8'h00;
        repeat (3) tick();
        check("rst_ack",  {31'b0, ack},       32'd0);
        check("rst_we",   {31'b0, mem_we},    32'd0);
        check("rst_busy", {31'b0, busy},      32'd0);
        check("rst_done", {31'b0, done},      32'd0);
        check("rst_err",  {31'b0, err},       32'd0);
        check("rst_run",  {31'b0, cpu_run_n}, 32'd0);
        check("rst_addr", {28'b0, mem_addr},  32'd0);
        check("rst_data", {24'b0, mem_data},  32'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_run",  {31'b0, cpu_run_n}, 32'd1);
        check("idle_busy", {31'b0, busy},      32'd0);

        // Strobe while idle must be ignored
        wq.delete();
        n_ack = 0;
        strobe = 1'b1; data_in = 8'h77;
        for (int i = 0; i < 8; i++) begin tick(); if (ack) n_ack++; end
        strobe = 1'b0;
        repeat (4) tick();
        check("idle_we_cnt",  wq.size(), 32'd0);
        check("idle_ack_cnt", n_ack,     32'd0);

        // Full image 0x10..0x1F
        wq.delete();
        pulse_load();
        check("load_busy", {31'b0, busy},      32'd1);
        check("load_run",  {31'b0, cpu_run_n}, 32'd0);
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
        check("full_done", {31'b0, done},      32'd1);
        check("full_run",  {31'b0, cpu_run_n}, 32'd1);
        check("full_busy", {31'b0, busy},      32'd0);
        check("full_we_cnt", wq.size(), 32'd16);
        for (int i = 0; i < 16 && i < wq.size(); i++) begin
            e = {4'(i), 8'h10 + 8'(i)};
            check("full_wr", {20'b0, wq[i]}, {20'b0, e});
        end

        // Held strobe: one write, ack held, 3-cycle latency
        wq.delete();
        pulse_load();
        check("reload_done", {31'b0, done}, 32'd0);
        n_ack = 0; first_ack = 0;
        strobe = 1'b1; data_in = 8'h55;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ack) begin
                n_ack++;
                if (first_ack == 0) first_ack = i;
            end
        end
        check("held_lat",    first_ack, 32'd3);
        check("held_ack",    n_ack,     32'd18);
        check("held_we_cnt", wq.size(), 32'd1);
        if (wq.size() > 0) check("held_wr", {20'b0, wq[0]}, {20'b0, 12'h055});
        strobe = 1'b0;
        n_fall = 0;
        while (ack && n_fall < 20) begin tick(); n_fall++; end
        check("ack_fall_lat", {31'b0, (n_fall >= 2 && n_fall <= 3)}, 32'd1);
        tick();

        // Abort after 5 bytes; next byte lands at address 0
        for (int i = 0; i < 4; i++) send_byte(8'h60 + 8'(i));
        check("pre_abort_addr", {28'b0, mem_addr}, 32'd5);
        wq.delete();
        pulse_load();
        check("abort_addr", {28'b0, mem_addr}, 32'd0);
        send_byte(8'hAA);
        check("abort_we_cnt", wq.size(), 32'd1);
        if (wq.size() > 0) check("abort_wr", {20'b0, wq[0]}, {20'b0, 12'h0AA});
        check("abort_busy", {31'b0, busy}, 32'd1);
        check("abort_done", {31'b0, done}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
        wq.delete();
        pulse_load();
        for (int i = 0; i < 16; i++) send_byte(8'h01);
        check("cks_wait_done", {31'b0, done}, 32'd0);
        send_byte(8'h10);
        check("cks_ok_done", {31'b0, done},      32'd1);
        check("cks_ok_err",  {31'b0, err},       32'd0);
        check("cks_ok_run",  {31'b0, cpu_run_n}, 32'd1);
        check("cks_we_cnt",  wq.size(),          32'd16);
        pulse_load();
        for (int i = 0; i < 16; i++) send_byte(8'h01);
        send_byte(8'h11);
        check("cks_bad_err",  {31'b0, err},       32'd1);
        check("cks_bad_done", {31'b0, done},      32'd1);
        check("cks_bad_run",  {31'b0, cpu_run_n}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
